// File: rtl/addsub_serial_pkg.sv
// Shared state encoding, operation select codes and sizing helper for the
// digit-serial adder/subtractor.
package addsub_serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic SEL_ADD = 1'b0;
   localparam logic SEL_SUB = 1'b1;

   // Number of digit steps needed to cover an operand.
   function automatic int unsigned num_digits(input int unsigned width,
                                              input int unsigned digit);
      return width / digit;
   endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit adder slice; b is inverted for subtraction so the
// caller only has to seed the carry with 1.
module addsub_digit
   import addsub_serial_pkg::*;
#(
   parameter int unsigned DIGIT = 2
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   input  logic             sel,
   output logic [DIGIT-1:0] d,
   output logic             cout
);

   logic [DIGIT-1:0] w_b_eff;
   logic [DIGIT:0]   w_sum;

   assign w_b_eff   = (sel == SEL_ADD) ? b : ~b;
   assign w_sum     = (DIGIT+1)'(a) + (DIGIT+1)'(w_b_eff) + (DIGIT+1)'(cin);
   assign {cout, d} = w_sum;

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor: one DIGIT-bit slice per
// clock under a start/busy/done handshake, with registered carry/ovf/zero flags.
module addsub_serial
   import addsub_serial_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned NDIG = num_digits(WIDTH, DIGIT);
   localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

   generate
      if ((DIGIT == 0) || (WIDTH < 2) || (WIDTH > 32) || (WIDTH % DIGIT != 0)) begin : g_bad_params
         $error("addsub_serial: WIDTH must be 2..32 and a multiple of DIGIT");
      end
   endgenerate

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic             w_accept;
   logic             w_last;

   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic             r_sel;
   logic             r_carry;
   logic             r_a_msb;
   logic             r_beff_msb;

   logic [DIGIT-1:0] w_d;
   logic             w_c;
   logic [WIDTH-1:0] w_res_nxt;

   addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .a    (r_a_sh[DIGIT-1:0]),
      .b    (r_b_sh[DIGIT-1:0]),
      .cin  (r_carry),
      .sel  (r_sel),
      .d    (w_d),
      .cout (w_c)
   );

   // New digit enters at the MSB end so the LSB digit ends up at bit 0.
   assign w_res_nxt = (r_res >> DIGIT) | (WIDTH'(w_d) << (WIDTH - DIGIT));

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_busy_nxt  = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (r_cnt == LAST_DIG) begin
               w_last      = 1'b1;
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_DONE;
            end else begin
               w_busy_nxt  = 1'b1;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath and result registers; results move only on the final digit.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         sum        <= '0;
         cout       <= 1'b0;
         ovf        <= 1'b0;
         zero       <= 1'b0;
         r_a_sh     <= '0;
         r_b_sh     <= '0;
         r_res      <= '0;
         r_cnt      <= '0;
         r_sel      <= 1'b0;
         r_carry    <= 1'b0;
         r_a_msb    <= 1'b0;
         r_beff_msb <= 1'b0;
      end else begin
         busy <= w_busy_nxt;
         done <= w_done_nxt;
         if (w_accept) begin
            r_a_sh     <= a;
            r_b_sh     <= b;
            r_sel      <= sel;
            r_carry    <= (sel == SEL_SUB);
            r_cnt      <= '0;
            r_a_msb    <= a[WIDTH-1];
            r_beff_msb <= b[WIDTH-1] ^ sel;
         end else if (r_state == ST_RUN) begin
            r_a_sh  <= r_a_sh >> DIGIT;
            r_b_sh  <= r_b_sh >> DIGIT;
            r_res   <= w_res_nxt;
            r_carry <= w_c;
            r_cnt   <= r_cnt + CW'(1);
         end
         if (w_last) begin
            sum  <= w_res_nxt;
            cout <= w_c;
            ovf  <= (r_a_msb == r_beff_msb) && (w_res_nxt[WIDTH-1] != r_a_msb);
            zero <= (w_res_nxt == '0);
         end
      end
   end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench: four addsub_serial configurations against a plain
// integer-arithmetic reference model.
module tb_addsub_serial;

   typedef struct packed {
      logic [31:0] s;
      logic        c;
      logic        v;
      logic        z;
   } res_t;

   logic clk;
   logic rst;
   logic        st [4];
   logic        sl [4];
   logic [31:0] av [4];
   logic [31:0] bv [4];
   logic        bs [4];
   logic        dn [4];
   logic        co [4];
   logic        ov [4];
   logic        zr [4];
   logic [31:0] sm [4];

   logic [3:0]  sum0;
   logic [7:0]  sum1;
   logic [7:0]  sum2;
   logic [31:0] sum3;

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   addsub_serial #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
      .clk(clk), .rst(rst), .start(st[0]), .sel(sl[0]), .a(av[0][3:0]), .b(bv[0][3:0]),
      .busy(bs[0]), .done(dn[0]), .sum(sum0), .cout(co[0]), .ovf(ov[0]), .zero(zr[0]));
   addsub_serial #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
      .clk(clk), .rst(rst), .start(st[1]), .sel(sl[1]), .a(av[1][7:0]), .b(bv[1][7:0]),
      .busy(bs[1]), .done(dn[1]), .sum(sum1), .cout(co[1]), .ovf(ov[1]), .zero(zr[1]));
   addsub_serial #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
      .clk(clk), .rst(rst), .start(st[2]), .sel(sl[2]), .a(av[2][7:0]), .b(bv[2][7:0]),
      .busy(bs[2]), .done(dn[2]), .sum(sum2), .cout(co[2]), .ovf(ov[2]), .zero(zr[2]));
   addsub_serial #(.WIDTH(32), .DIGIT(4)) u_w32d4 (
      .clk(clk), .rst(rst), .start(st[3]), .sel(sl[3]), .a(av[3]), .b(bv[3]),
      .busy(bs[3]), .done(dn[3]), .sum(sum3), .cout(co[3]), .ovf(ov[3]), .zero(zr[3]));

   assign sm[0] = 32'(sum0);
   assign sm[1] = 32'(sum1);
   assign sm[2] = 32'(sum2);
   assign sm[3] = sum3;

   function automatic int wid(input int k);
      case (k)
         0: return 4;
         1: return 8;
         2: return 8;
         default: return 32;
      endcase
   endfunction

   function automatic int ndig(input int k);
      case (k)
         0: return 4;
         1: return 4;
         2: return 1;
         default: return 8;
      endcase
   endfunction

   // Reference: modulo-2^w arithmetic, carry from the (w)th bit, overflow from signed range.
   function automatic res_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                  input logic sub);
      longint unsigned mask = (64'd1 << w) - 64'd1;
      longint unsigned half = 64'd1 << (w - 1);
      longint unsigned ua = 64'(x) & mask;
      longint unsigned ub = 64'(y) & mask;
      longint unsigned full;
      longint sa, sb, sr;
      res_t r;
      if (sub) full = ua + ((~ub) & mask) + 64'd1;
      else     full = ua + ub;
      sa = (ua >= half) ? longint'(ua) - longint'(mask + 64'd1) : longint'(ua);
      sb = (ub >= half) ? longint'(ub) - longint'(mask + 64'd1) : longint'(ub);
      sr = sub ? sa - sb : sa + sb;
      r.s = 32'(full & mask);
      r.c = ((full >> w) & 64'd1) != 64'd0;
      r.v = (sr > longint'(half) - 1) || (sr < -longint'(half));
      r.z = (r.s == 32'd0);
      return r;
   endfunction

   // Issue one operation and wait (bounded) for done; lat = -1 on timeout.
   task automatic run_op(input int k, input logic [31:0] x, input logic [31:0] y, input logic s,
                         output res_t got, output int lat, output int bcnt, output logic dn_after);
      @(negedge clk);
      st[k] = 1'b1; av[k] = x; bv[k] = y; sl[k] = s;
      @(posedge clk); #1;
      st[k] = 1'b0;
      lat  = 1;
      bcnt = (bs[k] === 1'b1) ? 1 : 0;
      while (dn[k] !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (bs[k] === 1'b1) bcnt++;
      end
      if (dn[k] !== 1'b1) lat = -1;
      got.s = sm[k]; got.c = co[k]; got.v = ov[k]; got.z = zr[k];
      @(posedge clk); #1;
      dn_after = dn[k];
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         st[k] = 1'b0; sl[k] = 1'b0; av[k] = '0; bv[k] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({bs[k], dn[k], co[k], ov[k], zr[k]} !== 5'b0 || sm[k] !== 32'd0) begin
            errors++;
            $display("FAIL reset k=%0d busy=%b done=%b sum=%h cout=%b ovf=%b zero=%b required all 0",
                     k, bs[k], dn[k], sm[k], co[k], ov[k], zr[k]);
         end
      end
   endtask

   task automatic test_directed();
      int          tk [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 2, 3};
      logic [31:0] ta [10] = '{5, 5, 1, 2, 7, 8, 32'h7F, 32'hFF, 32'h7F, 32'h7FFF_FFFF};
      logic [31:0] tb [10] = '{1, 1, 5, 2, 1, 1, 32'h01, 32'h01, 32'h01, 32'h1};
      logic        ts [10] = '{0, 1, 1, 1, 0, 1, 0, 0, 0, 0};
      logic [31:0] te [10] = '{6, 4, 32'hC, 0, 8, 7, 32'h80, 32'h00, 32'h80, 32'h8000_0000};
      res_t got, exp;
      int lat, bcnt;
      logic dn_after;
      for (int i = 0; i < 10; i++) begin
         run_op(tk[i], ta[i], tb[i], ts[i], got, lat, bcnt, dn_after);
         exp = model(wid(tk[i]), ta[i], tb[i], ts[i]);
         checks++;
         if (got.s !== te[i]) begin
            errors++;
            $display("FAIL directed_sum #%0d got %h required %h", i, got.s, te[i]);
         end
         checks++;
         if ({got.c, got.v, got.z} !== {exp.c, exp.v, exp.z}) begin
            errors++;
            $display("FAIL directed_flags #%0d c/v/z got %b%b%b required %b%b%b",
                     i, got.c, got.v, got.z, exp.c, exp.v, exp.z);
         end
         checks++;
         if (lat != ndig(tk[i]) + 1 || bcnt != ndig(tk[i]) || dn_after !== 1'b0) begin
            errors++;
            $display("FAIL directed_timing #%0d lat=%0d busy=%0d done_after=%b required %0d %0d 0",
                     i, lat, bcnt, dn_after, ndig(tk[i]) + 1, ndig(tk[i]));
         end
      end
   endtask

   task automatic test_random();
      res_t got, exp;
      int lat, bcnt;
      logic dn_after;
      logic [31:0] x, y, mask;
      logic s;
      for (int k = 0; k < 4; k++) begin
         mask = (wid(k) == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid(k)) - 32'd1);
         for (int n = 0; n < 15; n++) begin
            x = $urandom & mask;
            y = $urandom & mask;
            if ($urandom_range(0, 3) == 0) x = (mask >> 1) + 32'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) y = x;
            s = 1'($urandom_range(0, 1));
            run_op(k, x, y, s, got, lat, bcnt, dn_after);
            exp = model(wid(k), x, y, s);
            checks++;
            if (got !== exp || lat != ndig(k) + 1) begin
               errors++;
               $display("FAIL random k=%0d a=%h b=%h sel=%b got s=%h c=%b v=%b z=%b lat=%0d required s=%h c=%b v=%b z=%b lat=%0d",
                        k, x, y, s, got.s, got.c, got.v, got.z, lat, exp.s, exp.c, exp.v, exp.z, ndig(k) + 1);
            end
         end
      end
   endtask

   task automatic test_start_ignored();
      res_t exp = model(8, 32'h12, 32'h34, 1'b0);
      int n = 0;
      int pulses = 0;
      @(negedge clk);
      st[1] = 1'b1; av[1] = 32'h12; bv[1] = 32'h34; sl[1] = 1'b0;
      @(posedge clk); #1;
      st[1] = 1'b0;
      @(posedge clk); #1;
      st[1] = 1'b1; av[1] = 32'hAA; bv[1] = 32'h55; sl[1] = 1'b1;
      @(posedge clk); #1;
      st[1] = 1'b0;
      while (dn[1] !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (dn[1] !== 1'b1 || sm[1] !== exp.s) begin
         errors++;
         $display("FAIL start_in_run done=%b sum=%h required done=1 sum=%h", dn[1], sm[1], exp.s);
      end
      st[1] = 1'b1;
      @(posedge clk); #1;
      st[1] = 1'b0;
      checks++;
      if (bs[1] !== 1'b0 || dn[1] !== 1'b0) begin
         errors++;
         $display("FAIL start_in_done busy=%b done=%b required 0 0", bs[1], dn[1]);
      end
      repeat (8) begin
         @(posedge clk); #1;
         if (dn[1] === 1'b1 || bs[1] === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || sm[1] !== exp.s) begin
         errors++;
         $display("FAIL start_ignored_after activity=%0d sum=%h required 0 %h", pulses, sm[1], exp.s);
      end
   endtask

   task automatic test_back_to_back();
      res_t got, e1, e2;
      int lat, bcnt;
      int n = 0;
      logic dn_after;
      e1 = model(4, 32'h3, 32'h6, 1'b1);
      e2 = model(4, 32'h9, 32'h4, 1'b0);
      run_op(0, 32'h3, 32'h6, 1'b1, got, lat, bcnt, dn_after);
      checks++;
      if (got !== e1) begin
         errors++;
         $display("FAIL b2b_first got %h required %h", got.s, e1.s);
      end
      @(negedge clk);
      st[0] = 1'b1; av[0] = 32'h9; bv[0] = 32'h4; sl[0] = 1'b0;
      @(posedge clk); #1;
      st[0] = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bs[0] !== 1'b1 || sm[0] !== e1.s || co[0] !== e1.c) begin
         errors++;
         $display("FAIL b2b_hold busy=%b sum=%h cout=%b required 1 %h %b", bs[0], sm[0], co[0], e1.s, e1.c);
      end
      while (dn[0] !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (dn[0] !== 1'b1 || sm[0] !== e2.s || {co[0], ov[0], zr[0]} !== {e2.c, e2.v, e2.z}) begin
         errors++;
         $display("FAIL b2b_second done=%b sum=%h required 1 %h", dn[0], sm[0], e2.s);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_run();
      int pulses = 0;
      @(negedge clk);
      st[3] = 1'b1; av[3] = 32'hDEAD_BEEF; bv[3] = 32'h1234_5678; sl[3] = 1'b0;
      @(posedge clk); #1;
      st[3] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({bs[k], dn[k], co[k], ov[k], zr[k]} !== 5'b0 || sm[k] !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_run k=%0d busy=%b done=%b sum=%h required all 0", k, bs[k], dn[k], sm[k]);
         end
      end
      repeat (12) begin
         @(posedge clk); #1;
         if (dn[3] === 1'b1 || bs[3] === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL reset_mid_run_quiet activity=%0d required 0", pulses);
      end
   endtask

   task automatic test_reset_with_start();
      int pulses = 0;
      @(negedge clk);
      rst = 1'b1;
      st[1] = 1'b1; av[1] = 32'h10; bv[1] = 32'h20; sl[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      st[1] = 1'b0;
      checks++;
      if (bs[1] !== 1'b0) begin
         errors++;
         $display("FAIL reset_with_start busy=%b required 0", bs[1]);
      end
      repeat (8) begin
         @(posedge clk); #1;
         if (dn[1] === 1'b1 || bs[1] === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || sm[1] !== 32'd0) begin
         errors++;
         $display("FAIL reset_with_start_quiet activity=%0d sum=%h required 0 0", pulses, sm[1]);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_run();
      test_reset_with_start();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
